// File: rtl/comparer1_stim_chk.sv
// comparer1_stim_chk: steps a 1-bit comparator through all four input vectors and checks its LEDs
module comparer1_stim_chk #(
  parameter int DWELL_CYCLES   = 12000000,
  parameter int SETTLE_CYCLES  = 2,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       led1,
  input  logic       led2,
  input  logic       led3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec,
  output logic [1:0] cur_vec
);
  localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] SET_C = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] LAST_C = CW'(DWELL_CYCLES - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d, vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d, exp_lit, exp_led;
  logic [3:0] fail_q, fail_d;
  logic miss;
  // vector index doubles as {a,b}: zero in IDLE, held at 3 in DONE
  assign a = vec_q[1];
  assign b = vec_q[0];
  assign cur_vec = vec_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign pass = done && err_q == 3'd0;
  assign err_cnt = err_q;
  assign fail_vec = fail_q;
  assign exp_lit = {vec_q == 2'd2, vec_q[1] == vec_q[0], vec_q == 2'd1};
  assign exp_led = LED_ACTIVE_LOW ? ~exp_lit : exp_lit;
  assign miss = {led1, led2, led3} != exp_led;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vec_d = vec_q;
    err_d = err_q;
    fail_d = fail_q;
    if (state_q != RUN && start) begin
      state_d = RUN;
      cnt_d = '0;
      vec_d = 2'd0;
      err_d = 3'd0;
      fail_d = 4'd0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == SET_C && miss) begin
        err_d = err_q + 3'd1;
        fail_d[vec_q] = 1'b1;
      end
      if (cnt_q == LAST_C) begin
        cnt_d = '0;
        state_d = vec_q == 2'd3 ? DONE : RUN;
        vec_d = vec_q == 2'd3 ? vec_q : vec_q + 2'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vec_q <= 2'd0;
      err_q <= 3'd0;
      fail_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      err_q <= err_d;
      fail_q <= fail_d;
    end
  end
endmodule

// File: tb/tb_comparer1_stim_chk.sv
// tb_comparer1_stim_chk: drives two checker instances (active-low and active-high LEDs) against a faultable comparator model
module tb_comparer1_stim_chk;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic al, bl, ah, bh, busy_l, busy_h, done_l, done_h, pass_l, pass_h;
  logic [2:0] led_l, led_h, err_l, err_h, lit_l, lit_h, m;
  logic [3:0] fail_l, fail_h;
  logic [1:0] cv_l, cv_h;
  logic [2:0] cm [32];
  logic stuck2 = 1'b0;
  int ph = -1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  comparer1_stim_chk #(.DWELL_CYCLES(8), .SETTLE_CYCLES(2), .LED_ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .start(start), .a(al), .b(bl),
    .led1(led_l[2]), .led2(led_l[1]), .led3(led_l[0]),
    .busy(busy_l), .done(done_l), .pass(pass_l), .err_cnt(err_l), .fail_vec(fail_l), .cur_vec(cv_l));
  comparer1_stim_chk #(.DWELL_CYCLES(8), .SETTLE_CYCLES(2), .LED_ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .start(start), .a(ah), .b(bh),
    .led1(led_h[2]), .led2(led_h[1]), .led3(led_h[0]),
    .busy(busy_h), .done(done_h), .pass(pass_h), .err_cnt(err_h), .fail_vec(fail_h), .cur_vec(cv_h));

  function automatic logic [2:0] cmp(input logic x, input logic y);
    return {x & ~y, x == y, ~x & y};
  endfunction

  // board model: ideal comparator, optionally corrupted per run cycle or with led2 stuck unlit
  always_comb begin
    m = (ph >= 0 && ph < 32) ? cm[ph[4:0]] : 3'b000;
    lit_l = cmp(al, bl) ^ m;
    lit_h = cmp(ah, bh) ^ m;
    if (stuck2) begin
      lit_l[1] = 1'b0;
      lit_h[1] = 1'b0;
    end
    led_l = ~lit_l;
    led_h = lit_h;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_mode(input int mode);
    stuck2 = mode == 1;
    for (int i = 0; i < 32; i++)
      cm[i] = (mode == 4 || (mode == 2 && i % 8 < 2) || (mode == 3 && i == 10)) ? 3'b111 : 3'b000;
  endtask

  task automatic run(input int hold, input logic [2:0] e_err, input logic [3:0] e_fail);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 32; n++) begin
      ph = n;
      start = (n + 1 < hold);
      if (n % 8 == 0) begin
        chk("ab_lo", {al, bl}, n / 8);
        chk("ab_hi", {ah, bh}, n / 8);
        chk("busy", {busy_l, busy_h, done_l, done_h}, 4'b1100);
      end
      if (n == 1) chk("cleared", {err_l, fail_l, err_h, fail_h}, 0);
      @(posedge clk);
      #1;
    end
    ph = -1;
    chk("done_lo", {busy_l, done_l, pass_l}, {2'b01, e_err == 3'd0});
    chk("done_hi", {busy_h, done_h, pass_h}, {2'b01, e_err == 3'd0});
    chk("err_lo", err_l, e_err);
    chk("err_hi", err_h, e_err);
    chk("fail_lo", fail_l, e_fail);
    chk("fail_hi", fail_h, e_fail);
    repeat (3) @(posedge clk);
    #1;
    chk("hold", {done_l, al, bl, cv_l, err_l}, {1'b1, 2'b11, 2'd3, e_err});
  endtask

  typedef struct {
    int mode;
    int hold;
    logic [2:0] err;
    logic [3:0] fail;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [2:0] e_err;
    logic [3:0] e_fail;
    set_mode(0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {al, bl, busy_l, done_l, pass_l, err_l, fail_l, cv_l,
                  ah, bh, busy_h, done_h, pass_h, err_h, fail_h, cv_h}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle", {busy_l, done_l, al, bl}, 0);
    tbl[0] = '{0, 1, 3'd0, 4'b0000};
    tbl[1] = '{1, 1, 3'd2, 4'b1001};
    tbl[2] = '{0, 32, 3'd0, 4'b0000};
    tbl[3] = '{4, 1, 3'd4, 4'b1111};
    tbl[4] = '{2, 1, 3'd0, 4'b0000};
    tbl[5] = '{3, 1, 3'd1, 4'b0010};
    foreach (tbl[i]) begin
      set_mode(tbl[i].mode);
      run(tbl[i].hold, tbl[i].err, tbl[i].fail);
    end
    // abort mid-run while vector 2 is driven
    set_mode(1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    chk("cur_vec2", cv_l, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort", {al, bl, busy_l, done_l, cv_l, err_l, fail_l, busy_h, done_h, cv_h}, 0);
    set_mode(0);
    run(1, 3'd0, 4'b0000);
    // random per-cycle corruption: only the cnt==2 cycle of each vector counts
    for (int r = 0; r < 6; r++) begin
      stuck2 = 1'b0;
      for (int i = 0; i < 32; i++) cm[i] = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'b000;
      e_fail = 4'b0000;
      for (int v = 0; v < 4; v++) e_fail[v] = cm[8 * v + 2] != 3'b000;
      e_err = 3'($countones(e_fail));
      repeat ($urandom_range(3)) @(posedge clk);
      run($urandom_range(1, 20), e_err, e_fail);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
